// File: rtl/comb_pipe_alu.sv
// rtl/comb_pipe_alu.sv - opcode-selected logic/arith/select datapath in a 2-stage valid/ready pipeline
// Stage 1 holds operands, stage 2 holds results; op_count tallies output transfers.
module comb_pipe_alu #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHIFT_W-1:0] c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output logic               carry,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [2:0] {
    OP_LOGIC   = 3'd0,
    OP_ADDSHL  = 3'd1,
    OP_SEL     = 3'd2,
    OP_INV     = 3'd3,
    OP_SWAPINC = 3'd4
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               s1_valid_q, s1_valid_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [SHIFT_W-1:0] s1_c_q, s1_c_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  logic               s1_adv, s2_adv, out_fire;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   c_ext;
  logic [WIDTH-1:0]   alu_x, alu_y;
  logic               alu_carry;

  // The select/shift operand is folded into y at operand width.
  if (SHIFT_W >= WIDTH) begin : g_c_trunc
    assign c_ext = s1_c_q[WIDTH-1:0];
  end else begin : g_c_ext
    assign c_ext = {{(WIDTH-SHIFT_W){1'b0}}, s1_c_q};
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign out_fire = out_valid_q && out_ready;

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign y         = y_q;
  assign carry     = carry_q;
  assign op_count  = op_count_q;

  always_comb begin
    sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    alu_x     = '0;
    alu_y     = '0;
    alu_carry = 1'b0;
    case (s1_op_q)
      OP_LOGIC: begin
        alu_x = s1_a_q & s1_b_q;
        alu_y = s1_a_q | s1_b_q;
      end
      OP_ADDSHL: begin
        alu_carry = sum[WIDTH];
        alu_x     = (32'(s1_c_q) >= 32'(WIDTH)) ? '0 : (sum[WIDTH-1:0] << s1_c_q);
        alu_y     = (s1_a_q ^ s1_b_q) | c_ext;
      end
      OP_SEL: begin
        alu_x = s1_c_q[0] ? s1_a_q : s1_b_q;
        alu_y = alu_x;
      end
      OP_INV: begin
        alu_x = ~s1_a_q;
        alu_y = ~s1_b_q;
      end
      OP_SWAPINC: begin
        alu_x = s1_b_q + WIDTH'(1);
        alu_y = ~s1_a_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    carry_d     = carry_q;
    op_count_d  = op_count_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op;
        s1_a_d  = a;
        s1_b_d  = b;
        s1_c_d  = c;
      end
    end

    // Results only reload when a real beat moves up, so bubbles keep the last value.
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x_d     = alu_x;
        y_d     = alu_y;
        carry_d = alu_carry;
      end
    end

    if (cnt_clr) begin
      op_count_d = out_fire ? CNT_W'(1) : '0;
    end else if (out_fire && (op_count_q != CNT_MAX)) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      op_count_q  <= op_count_d;
    end
  end

endmodule

// File: tb/tb_comb_pipe_alu.sv
// tb/tb_comb_pipe_alu.sv - scoreboard bench for comb_pipe_alu
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_comb_pipe_alu;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready, in_ready2;
  logic [2:0] op;
  logic [7:0] a, b;
  logic [2:0] c;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic [7:0] x, y, x2, y2;
  logic       carry, carry2;
  logic       cnt_clr;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int npass  = 0;
  int ntotal = 0;

  logic [16:0] sb[$];
  int          exp_cnt  = 0;
  int          exp_cnt2 = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_out;

  comb_pipe_alu #(.WIDTH(8), .SHIFT_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .carry(carry), .cnt_clr(cnt_clr), .op_count(op_count)
  );

  comb_pipe_alu #(.WIDTH(8), .SHIFT_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .c(c), .out_valid(out_valid2), .out_ready(out_ready),
    .x(x2), .y(y2), .carry(carry2), .cnt_clr(cnt_clr), .op_count(op_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [2:0] o, input logic [7:0] ia, ib,
                                        input logic [2:0] ic);
    logic [8:0] s;
    logic [7:0] rx, ry;
    logic       cy;
    rx = 8'h00; ry = 8'h00; cy = 1'b0;
    case (o)
      3'd0: begin rx = ia & ib; ry = ia | ib; end
      3'd1: begin
        s  = {1'b0, ia} + {1'b0, ib};
        cy = s[8];
        rx = s[7:0] << ic;
        ry = (ia ^ ib) | {5'b0, ic};
      end
      3'd2: begin rx = ic[0] ? ia : ib; ry = rx; end
      3'd3: begin rx = ~ia; ry = ~ib; end
      3'd4: begin rx = ib + 8'd1; ry = ~ia; end
      default: ;
    endcase
    return {cy, rx, ry};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: drive at the negedge, sample mid-cycle, then wait for the next negedge.
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] ia, ib,
                      input logic [2:0] ic, input logic ordy, input logic clr,
                      input logic [16:0] expv, output logic fired);
    logic        out_fire;
    logic [16:0] got, want;
    in_valid = v; op = o; a = ia; b = ib; c = ic; out_ready = ordy; cnt_clr = clr;
    #1;
    check("op_count", 32'(op_count), 32'(exp_cnt));
    check("op_count_sat", 32'(op_count2), 32'(exp_cnt2));
    got = {carry, x, y};
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", 32'(got), 32'(prev_out));
    end
    out_fire = out_valid && out_ready;
    if (out_fire) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        want = sb.pop_front();
        check("result", 32'(got), 32'(want));
      end
    end
    fired = in_valid && in_ready;
    if (fired) sb.push_back(expv);
    if (clr) begin
      exp_cnt  = out_fire ? 1 : 0;
      exp_cnt2 = out_fire ? 1 : 0;
    end else if (out_fire) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = got;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic f;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 17'h0, f);
  endtask

  initial begin
    logic       f;
    logic [2:0] bop[3];
    logic [7:0] ba[3], bb[3];
    logic [2:0] bc[3];
    int         k, guard;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; c = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_xyc", 32'({carry, x, y}), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single LOGIC beat with latency check.
    step(1'b1, 3'd0, 8'hF0, 8'h3C, 3'd0, 1'b1, 1'b0, 17'h030FC, f);
    check("lat_fire", 32'(f), 32'd1);
    check("lat_c1", 32'(out_valid), 32'd0);
    idle(1);
    check("lat_c2", 32'(out_valid), 32'd1);
    idle(1);
    check("bubble", 32'(out_valid), 32'd0);
    check("count_one", 32'(op_count), 32'd1);

    // ADDSHL carry and shift overflow.
    step(1'b1, 3'd1, 8'hFF, 8'h02, 3'd3, 1'b1, 1'b0, 17'h108FF, f);
    step(1'b1, 3'd1, 8'h01, 8'h01, 3'd7, 1'b1, 1'b0, 17'h00007, f);
    idle(3);

    // Back-to-back SEL, INV, SWAPINC, reserved.
    step(1'b1, 3'd2, 8'h12, 8'hFF, 3'd1, 1'b1, 1'b0, 17'h01212, f);
    step(1'b1, 3'd3, 8'h12, 8'hFF, 3'd1, 1'b1, 1'b0, 17'h0ED00, f);
    step(1'b1, 3'd4, 8'h12, 8'hFF, 3'd1, 1'b1, 1'b0, 17'h000ED, f);
    step(1'b1, 3'd5, 8'h12, 8'hFF, 3'd1, 1'b1, 1'b0, 17'h00000, f);
    check("b2b_v4", 32'(out_valid), 32'd1);
    idle(1);
    check("b2b_v5", 32'(out_valid), 32'd1);
    idle(1);
    check("b2b_v6", 32'(out_valid), 32'd0);
    check("b2b_count", 32'(op_count), 32'd7);

    // Backpressure: three random beats, consumer stalled for five cycles.
    for (int i = 0; i < 3; i++) begin
      bop[i] = 3'($urandom_range(0, 7));
      ba[i]  = 8'($urandom);
      bb[i]  = 8'($urandom);
      bc[i]  = 3'($urandom);
    end
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step(k < 3, bop[k % 3], ba[k % 3], bb[k % 3], bc[k % 3], 1'b0, 1'b0,
           model(bop[k % 3], ba[k % 3], bb[k % 3], bc[k % 3]), f);
      if (f) k++;
    end
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_accepted", 32'(k), 32'd2);
    guard = 0;
    while ((k < 3 || sb.size() != 0) && guard < 20) begin
      step(k < 3, bop[k % 3], ba[k % 3], bb[k % 3], bc[k % 3], 1'b1, 1'b0,
           model(bop[k % 3], ba[k % 3], bb[k % 3], bc[k % 3]), f);
      if (f) k++;
      guard++;
    end
    check("bp_all_in", 32'(k), 32'd3);
    check("bp_drained", 32'(sb.size()), 32'd0);
    idle(1);

    // Counter saturation on the 2-bit instance, then clear with and without a transfer.
    for (int i = 0; i < 5; i++) begin
      bop[0] = 3'($urandom_range(0, 7)); ba[0] = 8'($urandom); bb[0] = 8'($urandom);
      bc[0] = 3'($urandom);
      step(1'b1, bop[0], ba[0], bb[0], bc[0], 1'b1, 1'b0, model(bop[0], ba[0], bb[0], bc[0]), f);
    end
    idle(3);
    check("sat_count", 32'(op_count2), 32'd3);
    step(1'b1, 3'd0, 8'hAA, 8'h0F, 3'd0, 1'b1, 1'b0, 17'h00AAF, f);
    idle(1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 17'h0, f);
    check("clr_xfer", 32'(op_count), 32'd1);
    check("clr_xfer_sat", 32'(op_count2), 32'd1);
    step(1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 17'h0, f);
    check("clr_idle", 32'(op_count), 32'd0);

    // Asynchronous reset mid-stream.
    step(1'b1, 3'd3, 8'h5A, 8'hA5, 3'd0, 1'b1, 1'b0, 17'h0A55A, f);
    step(1'b1, 3'd4, 8'h00, 8'hFF, 3'd0, 1'b1, 1'b0, 17'h000FF, f);
    step(1'b1, 3'd0, 8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0, 17'h0FFFF, f);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_xyc", 32'({carry, x, y}), 32'd0);
    check("arst_count", 32'(op_count), 32'd0);
    sb.delete();
    exp_cnt = 0; exp_cnt2 = 0; prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    step(1'b1, 3'd4, 8'h80, 8'hFF, 3'd0, 1'b1, 1'b0, 17'h0007F, f);
    check("post_rst_c1", 32'(out_valid), 32'd0);
    idle(1);
    check("post_rst_c2", 32'(out_valid), 32'd1);
    idle(2);
    check("final_drained", 32'(sb.size()), 32'd0);
    check("final_count", 32'(op_count), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/comb_pipe_alu.md
Name: comb_pipe_alu

Overview:
- Parametrised, pipelined successor to the team's single-cycle bitwise/arithmetic/select/packed-field combinational blocks.
- Merges those functions into one opcode-selected datapath with configurable width.
- Wraps the datapath in a 2-stage valid/ready pipeline with backpressure and a saturating transfer counter.
- Sits between a stimulus producer and a result consumer; both use valid/ready handshakes.

Parameters:
- WIDTH, 8, operand/result width (>=2).
- SHIFT_W, 3, width of shift/control input c (>=1).
- CNT_W, 8, width of transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- op  input  3  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  SHIFT_W  shift amount / select.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- x  output  WIDTH  primary result.
- y  output  WIDTH  secondary result.
- carry  output  1  adder carry-out (op 1 only).
- cnt_clr  input  1  synchronous clear of op_count.
- op_count  output  CNT_W  accepted output transfers, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids = 0, out_valid = 0, x = y = 0, carry = 0, op_count = 0, stage-1 operand registers = 0.
- Reset asserted mid-operation discards all in-flight beats.
- Pipeline structure:
  - Stage 1 registers {op, a, b, c} on an input transfer (in_valid && in_ready).
  - Stage 2 computes from the stage-1 registers and registers {x, y, carry}.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 beat/cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, x/y/carry/out_valid hold stable. Stage 1 also holds if it is full. No beat is dropped or duplicated.
- Opcodes (all results truncated to WIDTH; carry = 0 unless stated):
  - 0 LOGIC: x = a & b; y = a | b.
  - 1 ADDSHL: sum = a + b at WIDTH+1 bits; carry = sum[WIDTH]; x = sum[WIDTH-1:0] << c, zero fill, x = 0 if c >= WIDTH; y = (a ^ b) | zero-extended c, where c is truncated to WIDTH if SHIFT_W > WIDTH.
  - 2 SEL: x = y = c[0] ? a : b.
  - 3 INV: x = ~a; y = ~b.
  - 4 SWAPINC: x = b + 1, wrapping (all-ones -> 0); y = ~a.
  - 5-7 reserved: x = y = 0, carry = 0; the beat still flows and is counted.
- op_count:
  - Increments on each output transfer (out_valid && out_ready).
  - Saturates at 2^CNT_W - 1.
  - cnt_clr sets it to 0. If cnt_clr and a transfer occur in the same cycle, op_count = 1.
- Bubbles: out_valid deasserts the cycle after the last transfer if no new beat has reached stage 2.

Test Plan:
- Reset then single beat op=0, a=0xF0, b=0x3C, out_ready=1 -> out_valid high exactly 2 cycles after the transfer; x=0x30, y=0xFC, carry=0; op_count=1.
- op=1, a=0xFF, b=0x02, c=3 -> sum=0x101, carry=1, x=0x08, y=0xFD|0x03=0xFF; op=1, c=7, a=b=0x01 -> x=0x00.
- Back-to-back 4 beats, ops 2,3,4,5 with a=0x12, b=0xFF, c=1; out_ready=1 -> x/y sequence (0x12,0x12), (0xED,0x00), (0x00,0xED), (0x00,0x00); one result per cycle; op_count=4.
- Backpressure: stream 3 beats with out_ready low for 5 cycles -> in_ready low after both stages fill; x/y held stable; release -> all 3 beats emerge in order, none lost.
- Counter: CNT_W=2, 5 transfers -> op_count saturates at 3; assert cnt_clr together with a transfer -> op_count=1.
- Assert rst_n low mid-stream (asynchronously, between clock edges) -> out_valid, x, y and op_count drop to 0 immediately; after release, the first new beat appears with 2-cycle latency.
